// File: rtl/microcode_sequencer.sv
// -----------------------------------------------------------------------------
// microcode_sequencer
//   Control stage of the 8-bit datapath. A six-state T-ring (T1..T6) walks
//   every instruction through a common three-state fetch and a three-state
//   execute whose strobes are decoded from the opcode and, for conditional
//   jumps, from the ALU flags sampled in T4. HLT latches a halt that freezes
//   the ring in T4 until clr.
//
// Ports
//   clk             in   rising-edge clock
//   clr             in   asynchronous active-low reset
//   op_code         in   IR[7:4], valid from T4
//   carry_flag      in   ALU carry, consulted by JC in T4
//   zero_flag       in   ALU zero, consulted by JZ in T4
//   inc             out  PC increment (active-high)
//   pc_out_en       out  PC drives bus[3:0] (active-high)
//   low_ld_pc       out  PC load from bus (active-low)
//   low_ld_mar      out  MAR load (active-low)
//   low_mem_out_en  out  ROM drives bus (active-low)
//   low_ld_ir       out  IR load (active-low)
//   low_ir_out_en   out  IR[3:0] drives bus (active-low)
//   low_ld_acc      out  accumulator load (active-low)
//   acc_out_en      out  accumulator drives bus (active-high)
//   sub_add         out  ALU mode, 1 = subtract
//   subadd_out_en   out  ALU drives bus (active-high)
//   low_ld_b_reg    out  B register load (active-low)
//   low_ld_c        out  C register load (active-low)
//   low_ld_d        out  D register load (active-low)
//   low_ld_out_reg  out  output register load (active-low)
//   low_halt        out  halt, gates the clock buffer (active-low)
//   t_state         out  current T state, 0..5 = T1..T6
// -----------------------------------------------------------------------------
module microcode_sequencer #(
   parameter int OP_WIDTH    = 4,
   parameter bit HALT_STICKY = 1'b1
) (
   input  logic                clk,
   input  logic                clr,
   input  logic [OP_WIDTH-1:0] op_code,
   input  logic                carry_flag,
   input  logic                zero_flag,
   output logic                inc,
   output logic                pc_out_en,
   output logic                low_ld_pc,
   output logic                low_ld_mar,
   output logic                low_mem_out_en,
   output logic                low_ld_ir,
   output logic                low_ir_out_en,
   output logic                low_ld_acc,
   output logic                acc_out_en,
   output logic                sub_add,
   output logic                subadd_out_en,
   output logic                low_ld_b_reg,
   output logic                low_ld_c,
   output logic                low_ld_d,
   output logic                low_ld_out_reg,
   output logic                low_halt,
   output logic [2:0]          t_state
);

   typedef enum logic [2:0] {
      T1 = 3'd0,
      T2 = 3'd1,
      T3 = 3'd2,
      T4 = 3'd3,
      T5 = 3'd4,
      T6 = 3'd5
   } t_state_e;

   localparam logic [OP_WIDTH-1:0] OP_LDA  = OP_WIDTH'(4'h0);
   localparam logic [OP_WIDTH-1:0] OP_ADD  = OP_WIDTH'(4'h1);
   localparam logic [OP_WIDTH-1:0] OP_SUB  = OP_WIDTH'(4'h2);
   localparam logic [OP_WIDTH-1:0] OP_MOVC = OP_WIDTH'(4'h3);
   localparam logic [OP_WIDTH-1:0] OP_MOVD = OP_WIDTH'(4'h4);
   localparam logic [OP_WIDTH-1:0] OP_JMP  = OP_WIDTH'(4'h5);
   localparam logic [OP_WIDTH-1:0] OP_JC   = OP_WIDTH'(4'h6);
   localparam logic [OP_WIDTH-1:0] OP_JZ   = OP_WIDTH'(4'h7);
   localparam logic [OP_WIDTH-1:0] OP_OUT  = OP_WIDTH'(4'hE);
   localparam logic [OP_WIDTH-1:0] OP_HLT  = OP_WIDTH'(4'hF);

   t_state_e r_state;
   t_state_e w_next_state;
   logic     r_halt;
   logic     w_halt_set;

   // HLT is recognised combinationally in T4 so low_halt drops within T4 itself
   assign w_halt_set = (r_state == T4) && (op_code == OP_HLT);
   assign t_state    = r_state;

   // T-ring state register
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_state <= T1;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Halt latch: set by HLT in T4, cleared only by clr
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_halt <= 1'b0;
      end else if (w_halt_set) begin
         r_halt <= 1'b1;
      end else begin
         r_halt <= r_halt;
      end
   end

   // Next-state: advance around the ring unless halted or halting
   always_comb begin
      w_next_state = r_state;
      if (r_halt || w_halt_set) begin
         w_next_state = r_state;
      end else if (r_state == T6) begin
         w_next_state = T1;
      end else begin
         w_next_state = t_state_e'(r_state + 3'd1);
      end
   end

   // Halt output: sticky form holds it from T4 until clr
   always_comb begin
      low_halt = 1'b1;
      if (!clr) begin
         low_halt = 1'b1;
      end else if (HALT_STICKY) begin
         low_halt = !(r_halt || w_halt_set);
      end else begin
         low_halt = !w_halt_set;
      end
   end

   // Strobe decode from (state, opcode, flags); forced idle in reset or halt
   always_comb begin
      inc            = 1'b0;
      pc_out_en      = 1'b0;
      low_ld_pc      = 1'b1;
      low_ld_mar     = 1'b1;
      low_mem_out_en = 1'b1;
      low_ld_ir      = 1'b1;
      low_ir_out_en  = 1'b1;
      low_ld_acc     = 1'b1;
      acc_out_en     = 1'b0;
      sub_add        = 1'b0;
      subadd_out_en  = 1'b0;
      low_ld_b_reg   = 1'b1;
      low_ld_c       = 1'b1;
      low_ld_d       = 1'b1;
      low_ld_out_reg = 1'b1;
      if (clr && !r_halt) begin
         case (r_state)
            T1: begin
               pc_out_en  = 1'b1;
               low_ld_mar = 1'b0;
            end
            T2: inc = 1'b1;
            T3: begin
               low_mem_out_en = 1'b0;
               low_ld_ir      = 1'b0;
            end
            T4: begin
               case (op_code)
                  OP_LDA, OP_ADD, OP_SUB: begin
                     low_ir_out_en = 1'b0;
                     low_ld_mar    = 1'b0;
                  end
                  OP_MOVC: begin
                     acc_out_en = 1'b1;
                     low_ld_c   = 1'b0;
                  end
                  OP_MOVD: begin
                     acc_out_en = 1'b1;
                     low_ld_d   = 1'b0;
                  end
                  OP_JMP: begin
                     low_ir_out_en = 1'b0;
                     low_ld_pc     = 1'b0;
                  end
                  OP_JC: begin
                     low_ir_out_en = !carry_flag;
                     low_ld_pc     = !carry_flag;
                  end
                  OP_JZ: begin
                     low_ir_out_en = !zero_flag;
                     low_ld_pc     = !zero_flag;
                  end
                  OP_OUT: begin
                     acc_out_en     = 1'b1;
                     low_ld_out_reg = 1'b0;
                  end
                  default: inc = 1'b0;
               endcase
            end
            T5: begin
               case (op_code)
                  OP_LDA: begin
                     low_mem_out_en = 1'b0;
                     low_ld_acc     = 1'b0;
                  end
                  OP_ADD, OP_SUB: begin
                     low_mem_out_en = 1'b0;
                     low_ld_b_reg   = 1'b0;
                     // SUB sets the mode a cycle early so it is settled at T6
                     sub_add        = (op_code == OP_SUB);
                  end
                  default: inc = 1'b0;
               endcase
            end
            T6: begin
               case (op_code)
                  OP_ADD, OP_SUB: begin
                     subadd_out_en = 1'b1;
                     low_ld_acc    = 1'b0;
                     sub_add       = (op_code == OP_SUB);
                  end
                  default: inc = 1'b0;
               endcase
            end
            default: inc = 1'b0;
         endcase
      end else begin
         inc = 1'b0;
      end
   end

endmodule

// File: tb/tb_microcode_sequencer.sv
// -----------------------------------------------------------------------------
// tb_microcode_sequencer
//   Directed and randomised stimulus for microcode_sequencer. A step/halt
//   model plus a micro-op table gives the expected set of asserted strobes
//   for every cycle; hand-written literal checks pin the key sequences.
// -----------------------------------------------------------------------------
module tb_microcode_sequencer;

   logic       clk = 1'b0;
   logic       clr = 1'b1;
   logic [3:0] op_code = 4'h0;
   logic       carry_flag = 1'b0;
   logic       zero_flag = 1'b0;
   logic       inc, pc_out_en, low_ld_pc, low_ld_mar, low_mem_out_en, low_ld_ir;
   logic       low_ir_out_en, low_ld_acc, acc_out_en, sub_add, subadd_out_en;
   logic       low_ld_b_reg, low_ld_c, low_ld_d, low_ld_out_reg, low_halt;
   logic [2:0] t_state;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // micro-op bit positions, all in "asserted" sense
   localparam int INC = 0, PCO = 1, LPC = 2, LMAR = 3, MEMO = 4, LIR = 5, IRO = 6;
   localparam int LACC = 7, ACCO = 8, SUB = 9, ALUO = 10, LB = 11, LC = 12, LD = 13, LOUT = 14;

   microcode_sequencer #(.OP_WIDTH(4), .HALT_STICKY(1'b1)) dut (
      .clk(clk), .clr(clr), .op_code(op_code), .carry_flag(carry_flag), .zero_flag(zero_flag),
      .inc(inc), .pc_out_en(pc_out_en), .low_ld_pc(low_ld_pc), .low_ld_mar(low_ld_mar),
      .low_mem_out_en(low_mem_out_en), .low_ld_ir(low_ld_ir), .low_ir_out_en(low_ir_out_en),
      .low_ld_acc(low_ld_acc), .acc_out_en(acc_out_en), .sub_add(sub_add),
      .subadd_out_en(subadd_out_en), .low_ld_b_reg(low_ld_b_reg), .low_ld_c(low_ld_c),
      .low_ld_d(low_ld_d), .low_ld_out_reg(low_ld_out_reg), .low_halt(low_halt), .t_state(t_state)
   );

   always #5 clk = ~clk;

   logic [14:0] dut_mask;
   assign dut_mask = {~low_ld_out_reg, ~low_ld_d, ~low_ld_c, ~low_ld_b_reg, subadd_out_en, sub_add,
                      acc_out_en, ~low_ld_acc, ~low_ir_out_en, ~low_ld_ir, ~low_mem_out_en,
                      ~low_ld_mar, ~low_ld_pc, pc_out_en, inc};

   // behavioural model: instruction step 0..5 and sticky halt
   int m_step = 0;
   bit m_halt = 1'b0;

   always @(posedge clk or negedge clr) begin
      if (!clr) begin
         m_step <= 0;
         m_halt <= 1'b0;
      end else if (m_halt) begin
         m_step <= m_step;
      end else if (m_step == 3 && op_code == 4'hF) begin
         m_halt <= 1'b1;
      end else begin
         m_step <= (m_step + 1) % 6;
      end
   end

   function automatic logic [14:0] bitset(input int a, input int b, input int c);
      logic [14:0] v;
      v = '0;
      if (a >= 0) v[a] = 1'b1;
      if (b >= 0) v[b] = 1'b1;
      if (c >= 0) v[c] = 1'b1;
      return v;
   endfunction

   // micro-op table: which strobes an instruction asserts at each step
   function automatic logic [14:0] exp_mask(input int step, input logic [3:0] op,
                                            input logic c, input logic z, input bit halted);
      logic [14:0] e [3];
      e[0] = '0; e[1] = '0; e[2] = '0;
      if (halted) return '0;
      if (step == 0) return bitset(PCO, LMAR, -1);
      if (step == 1) return bitset(INC, -1, -1);
      if (step == 2) return bitset(MEMO, LIR, -1);
      case (op)
         4'h0: begin e[0] = bitset(IRO, LMAR, -1); e[1] = bitset(MEMO, LACC, -1); end
         4'h1: begin e[0] = bitset(IRO, LMAR, -1); e[1] = bitset(MEMO, LB, -1); e[2] = bitset(ALUO, LACC, -1); end
         4'h2: begin e[0] = bitset(IRO, LMAR, -1); e[1] = bitset(MEMO, LB, SUB); e[2] = bitset(ALUO, LACC, SUB); end
         4'h3: e[0] = bitset(ACCO, LC, -1);
         4'h4: e[0] = bitset(ACCO, LD, -1);
         4'h5: e[0] = bitset(IRO, LPC, -1);
         4'h6: e[0] = c ? bitset(IRO, LPC, -1) : 15'h0;
         4'h7: e[0] = z ? bitset(IRO, LPC, -1) : 15'h0;
         4'hE: e[0] = bitset(ACCO, LOUT, -1);
         default: e[0] = '0;
      endcase
      return e[step - 3];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // per-cycle compare of DUT against the model
   always @(negedge clk) begin
      if (chk_en) begin
         logic [14:0] em;
         bit          eh;
         int          drivers;
         em = clr ? exp_mask(m_step, op_code, carry_flag, zero_flag, m_halt) : 15'h0;
         eh = clr && (m_halt || (m_step == 3 && op_code == 4'hF));
         drivers = int'(pc_out_en) + int'(!low_mem_out_en) + int'(!low_ir_out_en)
                 + int'(acc_out_en) + int'(subadd_out_en);
         chk("model_tstate", 32'(t_state), 32'(m_step));
         chk("model_strobes", 32'(dut_mask), 32'(em));
         chk("model_halt", 32'(low_halt), 32'(!eh));
         chk("bus_exclusive", 32'(drivers <= 1), 32'd1);
      end
   end

   task automatic goto_t1();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(m_step == 0 && !m_halt) && n < 20);
      if (n >= 20) chk("sync_timeout", 32'd1, 32'd0);
   endtask

   // start an instruction at T1 and stop at the T4 sample point
   task automatic run_op(input logic [3:0] op, input logic c, input logic z);
      goto_t1();
      #1;
      op_code = op; carry_flag = c; zero_flag = z;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int cnt;
      #1 clr = 1'b0;
      #1 chk_en = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_tstate", 32'(t_state), 32'd0);
      chk("rst_strobes", 32'(dut_mask), 32'd0);
      chk("rst_halt", 32'(low_halt), 32'd1);

      // LDA walk-through
      @(posedge clk); #1 clr = 1'b1; op_code = 4'h0;
      @(negedge clk); chk("lda_t1", {t_state, pc_out_en, low_ld_mar}, {3'd0, 1'b1, 1'b0});
      @(negedge clk); chk("lda_t2", {t_state, inc}, {3'd1, 1'b1});
      @(negedge clk); chk("lda_t3", {t_state, low_mem_out_en, low_ld_ir}, {3'd2, 1'b0, 1'b0});
      @(negedge clk); chk("lda_t4", {t_state, low_ir_out_en, low_ld_mar}, {3'd3, 1'b0, 1'b0});
      @(negedge clk); chk("lda_t5", {t_state, low_mem_out_en, low_ld_acc}, {3'd4, 1'b0, 1'b0});
      @(negedge clk); chk("lda_t6", {t_state, dut_mask}, {3'd5, 15'h0});
      @(negedge clk); chk("lda_wrap", 32'(t_state), 32'd0);

      // SUB then ADD
      run_op(4'h2, 1'b0, 1'b0);
      @(negedge clk); chk("sub_t5", {low_ld_b_reg, sub_add}, {1'b0, 1'b1});
      @(negedge clk); chk("sub_t6", {subadd_out_en, sub_add, low_ld_acc}, {1'b1, 1'b1, 1'b0});
      run_op(4'h1, 1'b0, 1'b0);
      chk("add_t4_mode", 32'(sub_add), 32'd0);
      @(negedge clk); chk("add_t5", {low_ld_b_reg, sub_add}, {1'b0, 1'b0});
      @(negedge clk); chk("add_t6", {subadd_out_en, sub_add, low_ld_acc}, {1'b1, 1'b0, 1'b0});

      // conditional jumps, flag taken / not taken
      run_op(4'h6, 1'b1, 1'b0); chk("jc_taken", {low_ld_pc, low_ir_out_en}, 2'b00);
      run_op(4'h6, 1'b0, 1'b1); chk("jc_not", {low_ld_pc, low_ir_out_en}, 2'b11);
      #1 carry_flag = 1'b1;  // late flag change must not matter
      @(negedge clk); chk("jc_late_flag", 32'(low_ld_pc), 32'd1);
      run_op(4'h7, 1'b0, 1'b1); chk("jz_taken", {low_ld_pc, low_ir_out_en}, 2'b00);
      run_op(4'h7, 1'b1, 1'b0); chk("jz_not", {low_ld_pc, low_ir_out_en}, 2'b11);
      run_op(4'h5, 1'b0, 1'b0); chk("jmp", {low_ld_pc, low_ir_out_en}, 2'b00);
      run_op(4'h3, 1'b0, 1'b0); chk("movc", {acc_out_en, low_ld_c}, 2'b10);
      run_op(4'h4, 1'b0, 1'b0); chk("movd", {acc_out_en, low_ld_d}, 2'b10);
      run_op(4'hE, 1'b0, 1'b0); chk("out", {acc_out_en, low_ld_out_reg}, 2'b10);
      run_op(4'h9, 1'b0, 1'b0); chk("nop_t4", 32'(dut_mask), 32'd0);

      // HLT freezes at T4 until an asynchronous clr
      run_op(4'hF, 1'b0, 1'b0);
      chk("hlt_t4", {t_state, low_halt}, {3'd3, 1'b0});
      repeat (20) @(negedge clk);
      chk("hlt_frozen", {t_state, low_halt}, {3'd3, 1'b0});
      #2 clr = 1'b0;
      #1 chk("hlt_async_clr", {t_state, low_halt, dut_mask}, {3'd0, 1'b1, 15'h0});
      @(posedge clk); #1 clr = 1'b1; op_code = 4'h0;

      // abort ADD in T5, then confirm no accumulator load follows
      run_op(4'h1, 1'b0, 1'b0);
      @(negedge clk); chk("abort_t5", 32'(low_ld_b_reg), 32'd0);
      #2 clr = 1'b0;
      #1 chk("abort_idle", {t_state, dut_mask}, {3'd0, 15'h0});
      @(posedge clk); #1 clr = 1'b1; op_code = 4'h8;
      cnt = 0;
      @(negedge clk); chk("abort_restart", 32'(t_state), 32'd0);
      if (!low_ld_acc) cnt++;
      repeat (5) begin
         @(negedge clk);
         if (!low_ld_acc) cnt++;
      end
      chk("abort_no_acc", 32'(cnt), 32'd0);

      // random opcodes and flags; a halt is cleared with a one-cycle clr
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk); #1;
         clr        = m_halt ? 1'b0 : 1'b1;
         op_code    = 4'($urandom_range(0, 15));
         carry_flag = 1'($urandom_range(0, 1));
         zero_flag  = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1 clr = 1'b1;
      @(negedge clk);
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
